// File: rtl/mb_alu_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: ALUOp codes,
// command opcodes and FSM states.
package mb_alu_seq_pkg;

  // ALUOp encodings understood by the 8-bit ALU beside the sequencer
  localparam logic [4:0] ALU_ADD  = 5'b01101;
  localparam logic [4:0] ALU_XOR  = 5'b10000;
  localparam logic [4:0] ALU_AND  = 5'b01111;
  localparam logic [4:0] ALU_OR   = 5'b10101;
  localparam logic [4:0] ALU_LSR  = 5'b10001;
  localparam logic [4:0] ALU_LSRC = 5'b10010;
  localparam logic [4:0] ALU_LSL  = 5'b10011;
  localparam logic [4:0] ALU_LSLC = 5'b10100;
  localparam logic [4:0] ALU_CMP  = 5'b00101;
  localparam logic [4:0] ALU_NOP  = 5'b00000;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_LSL = 3'd1,
    OP_LSR = 3'd2,
    OP_CMP = 3'd3,
    OP_XOR = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_RSV = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Ops whose carry ripples from byte to byte and ends up in carry_out
  function automatic logic op_uses_carry(input cmd_op_e op);
    return (op == OP_ADD) || (op == OP_LSL) || (op == OP_LSR);
  endfunction

endpackage

// File: rtl/mb_alu_seq.sv
// Multi-byte ALU sequencer: walks an 8-bit ALU over a 1..MAX_BYTES operand,
// one byte per cycle, chaining carries and collecting result flags.
// Optional feature: define MB_ALU_SEQ_CMP_EN to enable the CMP command;
// without it cmd_op=3 is rejected like the reserved opcode.
module mb_alu_seq
  import mb_alu_seq_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  localparam int LEN_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [4:0]       alu_op,
  output logic             alu_ci,
  input  logic             alu_co,
  input  logic             alu_zero,
  input  logic             alu_equal,
  input  logic             alu_gt,
  input  logic             alu_lt,
  output logic [LEN_W-1:0] byte_idx,
  output logic             wr_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             carry_out,
  output logic             res_zero,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_lt
);

  state_e           state_q, state_d;
  cmd_op_e          op_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             carry_q;
  logic             zero_q;
  logic             err_q;
  logic             accept;
  logic             cmd_rsv;
  logic             first_byte;
  logic             last_byte;

  assign accept     = (state_q == ST_IDLE) && start;
  assign first_byte = (cnt_q == '0);
  assign last_byte  = (cnt_q == len_q);

`ifdef MB_ALU_SEQ_CMP_EN
  assign cmd_rsv = (cmd_op == 3'd7);
`else
  assign cmd_rsv = (cmd_op == 3'd7) || (cmd_op == 3'd3);
`endif

  // State register; reset lands in IDLE without passing through FIN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus all per-cycle ALU control, derived from the current byte
  always_comb begin
    state_d  = state_q;
    alu_op   = ALU_NOP;
    alu_ci   = 1'b0;
    wr_en    = 1'b0;
    byte_idx = '0;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = cmd_rsv ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        byte_idx = ((op_q == OP_LSR) || (op_q == OP_CMP)) ? (len_q - cnt_q) : cnt_q;
        wr_en    = (op_q != OP_CMP);
        case (op_q)
          OP_ADD: begin
            alu_op = ALU_ADD;
            alu_ci = first_byte ? 1'b0 : carry_q;
          end
          OP_LSL: begin
            alu_op = first_byte ? ALU_LSL : ALU_LSLC;
            alu_ci = first_byte ? 1'b0 : carry_q;
          end
          OP_LSR: begin
            alu_op = first_byte ? ALU_LSR : ALU_LSRC;
            alu_ci = first_byte ? 1'b0 : carry_q;
          end
          OP_CMP:  alu_op = ALU_CMP;
          OP_XOR:  alu_op = ALU_XOR;
          OP_AND:  alu_op = ALU_AND;
          OP_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_NOP;
        endcase
        if (last_byte || ((op_q == OP_CMP) && !alu_equal)) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, byte counter, carry chain and zero accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      len_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= cmd_op_e'(cmd_op);
      len_q   <= cmd_len;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= !cmd_rsv;
      err_q   <= cmd_rsv;
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q + 1'b1;
      if (op_uses_carry(op_q)) carry_q <= alu_co;
      if (wr_en) zero_q <= zero_q & alu_zero;
    end
  end

  assign carry_out = carry_q;
  assign res_zero  = zero_q;

`ifdef MB_ALU_SEQ_CMP_EN
  logic eq_q, gt_q, lt_q;

  // Comparison flags: first unequal byte decides gt/lt, full match sets eq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eq_q <= 1'b0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else if (accept) begin
      eq_q <= 1'b0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else if ((state_q == ST_RUN) && (op_q == OP_CMP)) begin
      if (!alu_equal) begin
        gt_q <= alu_gt;
        lt_q <= alu_lt;
      end else if (last_byte) begin
        eq_q <= 1'b1;
      end
    end
  end

  assign res_eq = eq_q;
  assign res_gt = gt_q;
  assign res_lt = lt_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^{alu_gt, alu_lt};
  assign res_eq = 1'b0;
  assign res_gt = 1'b0;
  assign res_lt = 1'b0;
`endif

endmodule

// File: tb/tb_mb_alu_seq.sv
// Directed testbench for mb_alu_seq. Inputs change 1ns after the rising
// edge and outputs are sampled in the same window.
module tb_mb_alu_seq;
  import mb_alu_seq_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] cmd_op;
  logic [1:0] cmd_len;
  logic [4:0] alu_op;
  logic       alu_ci;
  logic       alu_co, alu_zero, alu_equal, alu_gt, alu_lt;
  logic [1:0] byte_idx;
  logic       wr_en, busy, done, err;
  logic       carry_out, res_zero, res_eq, res_gt, res_lt;

  int tests_run;
  int tests_failed;

  mb_alu_seq #(.MAX_BYTES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .alu_op(alu_op), .alu_ci(alu_ci), .alu_co(alu_co), .alu_zero(alu_zero),
    .alu_equal(alu_equal), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .byte_idx(byte_idx), .wr_en(wr_en), .busy(busy), .done(done), .err(err),
    .carry_out(carry_out), .res_zero(res_zero), .res_eq(res_eq),
    .res_gt(res_gt), .res_lt(res_lt)
  );

  // Free-running 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; returns 1ns into cycle t+1
  task automatic issue(input logic [2:0] op, input logic [1:0] len);
    start   = 1'b1;
    cmd_op  = op;
    cmd_len = len;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    tests_run++;
    if ({busy, done, err, wr_en, alu_ci} !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctl: got %b expected 00000", {busy, done, err, wr_en, alu_ci});
    end
    tests_run++;
    if ({alu_op, byte_idx} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_op_idx: got %b expected 0000000", {alu_op, byte_idx});
    end
    tests_run++;
    if ({carry_out, res_zero, res_eq, res_gt, res_lt} !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {carry_out, res_zero, res_eq, res_gt, res_lt});
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_add();
    logic [1:0] co_seq [2];
    co_seq = '{2'd1, 2'd0};
    issue(3'd0, 2'd1);
    for (int i = 0; i < 2; i++) begin
      alu_co   = co_seq[i][0];
      alu_zero = (i == 1);
      tests_run++;
      if ({alu_op, alu_ci, byte_idx, wr_en, busy, done} !== {ALU_ADD, (i == 1), 2'(i), 3'b110}) begin
        tests_failed++;
        $display("[TB] FAIL add_byte%0d: got %b expected %b", i,
                 {alu_op, alu_ci, byte_idx, wr_en, busy, done}, {ALU_ADD, (i == 1), 2'(i), 3'b110});
      end
      step();
    end
    tests_run++;
    if ({done, err, wr_en, carry_out, res_zero} !== 5'b10000) begin
      tests_failed++;
      $display("[TB] FAIL add_done: got %b expected 10000", {done, err, wr_en, carry_out, res_zero});
    end
    step();
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL add_idle: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_lsr();
    logic [4:0] exp_op;
    issue(3'd2, 2'd3);
    for (int i = 0; i < 4; i++) begin
      alu_co   = 1'b1;
      alu_zero = 1'b1;
      exp_op   = (i == 0) ? 5'b10001 : 5'b10010;
      tests_run++;
      if ({alu_op, alu_ci, byte_idx, wr_en, done} !== {exp_op, (i != 0), 2'(3 - i), 2'b10}) begin
        tests_failed++;
        $display("[TB] FAIL lsr_byte%0d: got %b expected %b", i,
                 {alu_op, alu_ci, byte_idx, wr_en, done}, {exp_op, (i != 0), 2'(3 - i), 2'b10});
      end
      step();
    end
    tests_run++;
    if ({done, err, carry_out, res_zero} !== 4'b1011) begin
      tests_failed++;
      $display("[TB] FAIL lsr_done: got %b expected 1011", {done, err, carry_out, res_zero});
    end
    step();
  endtask

  task automatic test_lsl();
    logic co_seq [3];
    logic ci_exp [3];
    logic [4:0] exp_op;
    co_seq = '{1'b1, 1'b0, 1'b1};
    ci_exp = '{1'b0, 1'b1, 1'b0};
    issue(3'd1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      alu_co   = co_seq[i];
      alu_zero = 1'b1;
      exp_op   = (i == 0) ? 5'b10011 : 5'b10100;
      tests_run++;
      if ({alu_op, alu_ci, byte_idx, wr_en} !== {exp_op, ci_exp[i], 2'(i), 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL lsl_byte%0d: got %b expected %b", i,
                 {alu_op, alu_ci, byte_idx, wr_en}, {exp_op, ci_exp[i], 2'(i), 1'b1});
      end
      step();
    end
    tests_run++;
    if ({done, carry_out, res_zero} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL lsl_done: got %b expected 111", {done, carry_out, res_zero});
    end
    step();
  endtask

  task automatic test_logic();
    logic [2:0] ops [3];
    logic [4:0] codes [3];
    ops   = '{3'd4, 3'd5, 3'd6};
    codes = '{5'b10000, 5'b01111, 5'b10101};
    for (int k = 0; k < 3; k++) begin
      issue(ops[k], 2'd0);
      alu_co   = 1'b1;
      alu_zero = 1'b0;
      tests_run++;
      if ({alu_op, alu_ci, byte_idx, wr_en} !== {codes[k], 1'b0, 2'd0, 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL logic_op%0d: got %b expected %b", ops[k],
                 {alu_op, alu_ci, byte_idx, wr_en}, {codes[k], 1'b0, 2'd0, 1'b1});
      end
      step();
      tests_run++;
      if ({done, err, carry_out, res_zero} !== 4'b1000) begin
        tests_failed++;
        $display("[TB] FAIL logic_done%0d: got %b expected 1000", ops[k], {done, err, carry_out, res_zero});
      end
      step();
    end
  endtask

  task automatic test_reserved();
    alu_co = 1'b1;
    issue(3'd7, 2'd3);
    tests_run++;
    if ({busy, done, err, wr_en, carry_out} !== 5'b11100) begin
      tests_failed++;
      $display("[TB] FAIL rsv_fin: got %b expected 11100", {busy, done, err, wr_en, carry_out});
    end
    issue(3'd0, 2'd0);
    tests_run++;
    if ({busy, done, err, wr_en} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL rsv_start_ignored: got %b expected 0000", {busy, done, err, wr_en});
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    issue(3'd0, 2'd3);
    alu_co   = 1'b1;
    alu_zero = 1'b0;
    step();
    tests_run++;
    if ({busy, byte_idx, carry_out} !== 4'b1011) begin
      tests_failed++;
      $display("[TB] FAIL midrun_pre: got %b expected 1011", {busy, byte_idx, carry_out});
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, err, wr_en, alu_ci, alu_op, byte_idx, carry_out, res_zero} !== 14'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset: got %b expected 0",
               {busy, done, err, wr_en, alu_ci, alu_op, byte_idx, carry_out, res_zero});
    end
    step();
    reset = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL midrun_no_done: got %b expected 00", {busy, done});
    end
    alu_co   = 1'b0;
    alu_zero = 1'b1;
    issue(3'd0, 2'd0);
    tests_run++;
    if ({alu_op, byte_idx, wr_en, done} !== {ALU_ADD, 2'd0, 2'b10}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_add: got %b expected %b", {alu_op, byte_idx, wr_en, done}, {ALU_ADD, 2'd0, 2'b10});
    end
    step();
    tests_run++;
    if ({done, err, carry_out, res_zero} !== 4'b1001) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_done: got %b expected 1001", {done, err, carry_out, res_zero});
    end
    step();
  endtask

`ifdef MB_ALU_SEQ_CMP_EN
  task automatic test_cmp();
    logic eq_seq [3];
    eq_seq = '{1'b1, 1'b1, 1'b0};
    issue(3'd3, 2'd3);
    for (int i = 0; i < 3; i++) begin
      alu_equal = eq_seq[i];
      alu_gt    = (i == 2);
      alu_lt    = 1'b0;
      tests_run++;
      if ({alu_op, byte_idx, wr_en, done} !== {ALU_CMP, 2'(3 - i), 2'b00}) begin
        tests_failed++;
        $display("[TB] FAIL cmp_byte%0d: got %b expected %b", i,
                 {alu_op, byte_idx, wr_en, done}, {ALU_CMP, 2'(3 - i), 2'b00});
      end
      step();
    end
    tests_run++;
    if ({done, err, res_eq, res_gt, res_lt} !== 5'b10010) begin
      tests_failed++;
      $display("[TB] FAIL cmp_done: got %b expected 10010", {done, err, res_eq, res_gt, res_lt});
    end
    step();
    issue(3'd3, 2'd1);
    alu_equal = 1'b1;
    alu_gt    = 1'b0;
    step();
    step();
    tests_run++;
    if ({done, res_eq, res_gt, res_lt} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL cmp_equal: got %b expected 1100", {done, res_eq, res_gt, res_lt});
    end
    step();
  endtask
`else
  task automatic test_cmp_disabled();
    issue(3'd3, 2'd1);
    tests_run++;
    if ({busy, done, err, wr_en, res_eq, res_gt, res_lt} !== 7'b1110000) begin
      tests_failed++;
      $display("[TB] FAIL cmp_disabled: got %b expected 1110000", {busy, done, err, wr_en, res_eq, res_gt, res_lt});
    end
    step();
  endtask
`endif

  // Runs each scenario in turn, then reports totals
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    start     = 1'b0;
    cmd_op    = 3'd0;
    cmd_len   = 2'd0;
    alu_co    = 1'b0;
    alu_zero  = 1'b0;
    alu_equal = 1'b0;
    alu_gt    = 1'b0;
    alu_lt    = 1'b0;
    test_reset();
    test_add();
    test_lsr();
    test_lsl();
    test_logic();
    test_reserved();
    test_reset_mid_run();
`ifdef MB_ALU_SEQ_CMP_EN
    test_cmp();
`else
    test_cmp_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
